// File: rtl/game_over_controller.sv
// game_over_controller: game-over banner sequencer (drop-in, animate, hold, restart) with game freeze
module game_over_controller #(
   parameter int WIDTH        = 73,
   parameter int SCREEN_W     = 576,
   parameter int SCREEN_H     = 240,
   parameter int Y_FINAL      = 115,
   parameter int DROP_STEP    = 1,
   parameter int FRAME_PERIOD = 30,
   parameter int HOLD_FRAMES  = 180
) (
   input  logic        pixel_clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        collision_info,
   input  logic [11:0] offset_background,
   input  logic        restart_in,
   output logic [12:0] x_out,
   output logic [9:0]  y_out,
   output logic        unique_image_index,
   output logic        banner_visible,
   output logic        freeze_out,
   output logic        restart_pulse
);
   localparam int FW = FRAME_PERIOD > 1 ? $clog2(FRAME_PERIOD) : 1;
   localparam int HW = HOLD_FRAMES > 1 ? $clog2(HOLD_FRAMES) : 1;
   typedef enum logic [1:0] {PLAY, DROPPING, SHOWING, WAIT_RESTART} state_t;
   state_t state;
   logic [FW-1:0] frame_cnt;
   logic [HW-1:0] hold_cnt;
   logic restart_q;
   logic frame_strobe, restart_rise;
   logic [10:0] y_step, y_next;
   assign frame_strobe = hcount_in == 11'd0 && vcount_in == 10'(SCREEN_H);
   assign restart_rise = restart_in & ~restart_q;
   assign y_step = {1'b0, y_out} + 11'(DROP_STEP);
   assign y_next = y_step > 11'(Y_FINAL) ? 11'(Y_FINAL) : y_step;
   // Sequencer: capture on collision, drop per frame, animate and hold, then wait for a fresh restart press
   always_ff @(posedge pixel_clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state              <= PLAY;
         x_out              <= '0;
         y_out              <= '0;
         unique_image_index <= 1'b0;
         banner_visible     <= 1'b0;
         freeze_out         <= 1'b0;
         restart_pulse      <= 1'b0;
         frame_cnt          <= '0;
         hold_cnt           <= '0;
         restart_q          <= 1'b0;
      end else begin
         restart_q     <= restart_in;
         restart_pulse <= 1'b0;
         case (state)
            PLAY: if (collision_info) begin
               state              <= DROPPING;
               x_out              <= 13'(offset_background) + 13'((SCREEN_W - WIDTH) / 2);
               y_out              <= '0;
               unique_image_index <= 1'b0;
               frame_cnt          <= '0;
               hold_cnt           <= '0;
               banner_visible     <= 1'b1;
               freeze_out         <= 1'b1;
            end
            DROPPING: if (frame_strobe) begin
               y_out <= y_next[9:0];
               if (y_next == 11'(Y_FINAL)) begin
                  state     <= SHOWING;
                  frame_cnt <= '0;
                  hold_cnt  <= '0;
               end
            end
            SHOWING, WAIT_RESTART: begin
               if (state == WAIT_RESTART && restart_rise) begin
                  state              <= PLAY;
                  restart_pulse      <= 1'b1;
                  banner_visible     <= 1'b0;
                  freeze_out         <= 1'b0;
                  y_out              <= '0;
                  unique_image_index <= 1'b0;
               end else if (frame_strobe) begin
                  unique_image_index <= frame_cnt == FW'(FRAME_PERIOD - 1) ? ~unique_image_index : unique_image_index;
                  frame_cnt          <= frame_cnt == FW'(FRAME_PERIOD - 1) ? '0 : frame_cnt + 1'b1;
                  if (state == SHOWING) begin
                     state    <= hold_cnt == HW'(HOLD_FRAMES - 1) ? WAIT_RESTART : SHOWING;
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            default: state <= PLAY;
         endcase
      end
   end
endmodule

// File: tb/tb_game_over_controller.sv
// tb_game_over_controller: directed self-checking bench for the game-over banner sequencer
module tb_game_over_controller;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] hcount = 11'd5;
   logic [9:0]  vcount = 10'd0;
   logic        collision = 1'b1;
   logic [11:0] offset = 12'd100;
   logic        restart = 1'b0;
   logic [12:0] x_out;
   logic [9:0]  y_out;
   logic        idx, vis, frz, pulse;
   int n_checks = 0;
   int n_fails = 0;

   game_over_controller #(
      .Y_FINAL(5), .DROP_STEP(2), .FRAME_PERIOD(2), .HOLD_FRAMES(4)
   ) dut (
      .pixel_clk_in(clk), .rst_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
      .collision_info(collision), .offset_background(offset), .restart_in(restart),
      .x_out(x_out), .y_out(y_out), .unique_image_index(idx), .banner_visible(vis),
      .freeze_out(frz), .restart_pulse(pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe();
      hcount = 11'd0;
      vcount = 10'd240;
      tick();
      hcount = 11'd5;
      vcount = 10'd0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_x"}, x_out, 0);
      chk({tag, "_y"}, y_out, 0);
      chk({tag, "_idx"}, idx, 0);
      chk({tag, "_vis"}, vis, 0);
      chk({tag, "_frz"}, frz, 0);
      chk({tag, "_pulse"}, pulse, 0);
   endtask

   initial begin
      repeat (2) tick();
      chk_idle("reset");
      rst_n = 1'b1;
      tick();
      chk("cap_frz", frz, 1);
      chk("cap_vis", vis, 1);
      chk("cap_x", x_out, 351);
      chk("cap_y", y_out, 0);
      collision = 1'b0;
      offset = 12'd500;
      tick();
      chk("idle_y", y_out, 0);
      strobe();
      chk("drop_y1", y_out, 2);
      strobe();
      chk("drop_y2", y_out, 4);
      strobe();
      chk("drop_sat", y_out, 5);
      chk("x_held", x_out, 351);
      tick();
      chk("hold_y", y_out, 5);
      strobe();
      chk("anim_s1", idx, 0);
      strobe();
      chk("anim_s2", idx, 1);
      strobe();
      chk("anim_s3", idx, 1);
      restart = 1'b1;
      tick();
      chk("show_ignores_restart", frz, 1);
      restart = 1'b0;
      tick();
      restart = 1'b1;
      tick();
      chk("show_ignores_press", frz, 1);
      strobe();
      chk("anim_s4", idx, 0);
      chk("wait_y", y_out, 5);
      repeat (3) tick();
      chk("held_button_no_edge", frz, 1);
      chk("held_no_pulse", pulse, 0);
      restart = 1'b0;
      tick();
      chk("release_frz", frz, 1);
      restart = 1'b1;
      tick();
      chk("rst_pulse", pulse, 1);
      chk("rst_frz", frz, 0);
      chk("rst_vis", vis, 0);
      chk("rst_y", y_out, 0);
      tick();
      chk("pulse_one_cycle", pulse, 0);
      chk("play_frz", frz, 0);
      restart = 1'b0;
      collision = 1'b1;
      tick();
      chk("recap_frz", frz, 1);
      chk("recap_x", x_out, 751);
      collision = 1'b0;
      repeat (3) strobe();
      chk("redrop_y", y_out, 5);
      repeat (4) strobe();
      chk("wait2_idx0", idx, 0);
      repeat (2) strobe();
      chk("wait_anim_idx", idx, 1);
      hcount = 11'd0;
      vcount = 10'd240;
      restart = 1'b1;
      collision = 1'b1;
      tick();
      hcount = 11'd5;
      vcount = 10'd0;
      chk("sim_pulse", pulse, 1);
      chk("sim_idx", idx, 0);
      chk("sim_coll_ignored", frz, 0);
      tick();
      chk("next_coll_frz", frz, 1);
      chk("next_coll_pulse", pulse, 0);
      collision = 1'b0;
      restart = 1'b0;
      strobe();
      strobe();
      chk("pre_async_y", y_out, 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle("async");
      tick();
      chk("async_pulse", pulse, 0);
      rst_n = 1'b1;
      tick();
      chk("post_async_frz", frz, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
